// File: rtl/plc_timer_bank.sv
// Bank of NCH independent PLC-style on-delay timers with manual override, estop fault latch and preset port.
// Optional off-delay (TOF) behaviour is enabled by defining the PLC_TOF_EN macro.
module plc_timer_bank #(
  parameter int NCH        = 4,
  parameter int CW         = 28,
  parameter int DEF_PRESET = 20,
  parameter int TOF_PRESET = 10,
  localparam int AW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] auto_mode,
  input  logic [NCH-1:0] man_mode,
  input  logic           estop,
  input  logic           fault_clr,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [CW-1:0]  cfg_data,
  output logic [NCH-1:0] ctrl_out,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] conflict,
  output logic           fault
);

`ifdef PLC_TOF_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TIMING = 2'd1, S_ON = 2'd2, S_OFF_DELAY = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TIMING = 2'd1, S_ON = 2'd2} state_e;
`endif

  logic fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (ena) begin
      if (estop)          fault_q <= 1'b1;
      else if (fault_clr) fault_q <= 1'b0;
    end
  end

  assign fault = fault_q;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d, cnt_sat, preset_q;
      logic [CW:0]   cnt_inc;
      logic          go, both;
      logic          ctrl_q, busy_q, conflict_q;

      assign both    = start[gi] & auto_mode[gi] & man_mode[gi];
      assign go      = start[gi] & (auto_mode[gi] ^ man_mode[gi]);
      // One extra bit so the preset comparison never sees a wrapped value.
      assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
      assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (estop || fault_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (go) begin
                cnt_d = '0;
                if (man_mode[gi] || preset_q == '0) state_d = S_ON;
                else                                state_d = S_TIMING;
              end
            end
            S_TIMING: begin
              if (!go) begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end else if (man_mode[gi] || cnt_inc >= {1'b0, preset_q}) begin
                // >= also catches a preset lowered below the running count.
                state_d = S_ON;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_sat;
              end
            end
            S_ON: begin
              if (!go) begin
                cnt_d = '0;
`ifdef PLC_TOF_EN
                state_d = S_OFF_DELAY;
`else
                state_d = S_IDLE;
`endif
              end
            end
`ifdef PLC_TOF_EN
            S_OFF_DELAY: begin
              if (go) begin
                state_d = S_ON;
                cnt_d   = '0;
              end else if (cnt_inc >= (CW+1)'(TOF_PRESET)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_sat;
              end
            end
`endif
            default: begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          preset_q   <= CW'(DEF_PRESET);
          ctrl_q     <= 1'b0;
          busy_q     <= 1'b0;
          conflict_q <= 1'b0;
        end else if (ena) begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          if (cfg_we && cfg_addr == AW'(gi)) preset_q <= cfg_data;
          // Outputs decode the next state so they line up with the state register.
`ifdef PLC_TOF_EN
          ctrl_q <= (state_d == S_ON) || (state_d == S_OFF_DELAY);
          busy_q <= (state_d == S_TIMING) || (state_d == S_OFF_DELAY);
`else
          ctrl_q <= (state_d == S_ON);
          busy_q <= (state_d == S_TIMING);
`endif
          conflict_q <= both;
        end
      end

      assign ctrl_out[gi] = ctrl_q;
      assign busy[gi]     = busy_q;
      assign conflict[gi] = conflict_q;
    end
  endgenerate

endmodule

// File: tb/tb_plc_timer_bank.sv
// Directed self-checking bench for plc_timer_bank (default parameters, PLC_TOF_EN optional).
module tb_plc_timer_bank;

  localparam int NCH = 4;
  localparam int CW  = 28;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           ena = 1'b1;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] auto_mode = '0;
  logic [NCH-1:0] man_mode = '0;
  logic           estop = 1'b0;
  logic           fault_clr = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_addr = '0;
  logic [CW-1:0]  cfg_data = '0;
  logic [NCH-1:0] ctrl_out, busy, conflict;
  logic           fault;

  int checks = 0;
  int failures = 0;

  plc_timer_bank #(.NCH(NCH), .CW(CW), .DEF_PRESET(20), .TOF_PRESET(10)) dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .auto_mode(auto_mode),
    .man_mode(man_mode), .estop(estop), .fault_clr(fault_clr), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ctrl_out(ctrl_out), .busy(busy),
    .conflict(conflict), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [CW-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    tick(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    $display("[tb] reset asserted");
    chk("rst_ctrl", 32'(ctrl_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_conflict", 32'(conflict), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(1);

    $display("[tb] ch0 auto on-delay, preset 20");
    auto_mode[0] = 1'b1; start[0] = 1'b1;
    tick(1);
    chk("a_busy_e0", 32'(busy[0]), 32'h1);
    chk("a_ctrl_e0", 32'(ctrl_out[0]), 32'h0);
    for (int k = 1; k < 20; k++) begin
      tick(1);
      chk("a_ctrl_wait", 32'(ctrl_out[0]), 32'h0);
      chk("a_busy_wait", 32'(busy[0]), 32'h1);
    end
    tick(1);
    chk("a_ctrl_e20", 32'(ctrl_out[0]), 32'h1);
    chk("a_busy_e20", 32'(busy[0]), 32'h0);

    $display("[tb] ch1 manual on/off");
    man_mode[1] = 1'b1; start[1] = 1'b1;
    tick(1);
    chk("m_ctrl_on", 32'(ctrl_out[1]), 32'h1);
    chk("m_busy_on", 32'(busy[1]), 32'h0);
    start[1] = 1'b0;
    tick(1);
`ifdef PLC_TOF_EN
    chk("m_tof_hold", 32'(ctrl_out[1]), 32'h1);
    chk("m_tof_busy", 32'(busy[1]), 32'h1);
    tick(9);
    chk("m_tof_last", 32'(ctrl_out[1]), 32'h1);
    tick(1);
    chk("m_tof_off", 32'(ctrl_out[1]), 32'h0);
`else
    chk("m_ctrl_off", 32'(ctrl_out[1]), 32'h0);
`endif

    $display("[tb] ch2 preset 5 then lowered preset");
    cfg_write(2'd2, 28'd5);
    auto_mode[2] = 1'b1; start[2] = 1'b1;
    tick(1);
    chk("c_busy_e0", 32'(busy[2]), 32'h1);
    tick(4);
    chk("c_ctrl_e4", 32'(ctrl_out[2]), 32'h0);
    tick(1);
    chk("c_ctrl_e5", 32'(ctrl_out[2]), 32'h1);
    start[2] = 1'b0;
    tick(12);
    chk("c_ctrl_stop", 32'(ctrl_out[2]), 32'h0);
    cfg_write(2'd2, 28'd10);
    start[2] = 1'b1;
    tick(5);
    chk("c2_ctrl_e4", 32'(ctrl_out[2]), 32'h0);
    cfg_write(2'd2, 28'd2);
    chk("c2_ctrl_wr", 32'(ctrl_out[2]), 32'h0);
    tick(1);
    chk("c2_ctrl_low", 32'(ctrl_out[2]), 32'h1);

    $display("[tb] ch3 mode conflict");
    auto_mode[3] = 1'b1; man_mode[3] = 1'b1; start[3] = 1'b1;
    tick(1);
    chk("d_conflict", 32'(conflict[3]), 32'h1);
    chk("d_ctrl", 32'(ctrl_out[3]), 32'h0);
    chk("d_busy", 32'(busy[3]), 32'h0);
    man_mode[3] = 1'b0;
    tick(1);
    chk("d_conflict_clr", 32'(conflict[3]), 32'h0);
    chk("d_busy_auto", 32'(busy[3]), 32'h1);

    $display("[tb] ch3 enable freeze at count 10");
    tick(10);
    ena = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 28'd1;
    tick(7);
    cfg_we = 1'b0;
    chk("e_ctrl_frozen", 32'(ctrl_out[3]), 32'h0);
    chk("e_busy_frozen", 32'(busy[3]), 32'h1);
    ena = 1'b1;
    tick(9);
    chk("e_ctrl_e19", 32'(ctrl_out[3]), 32'h0);
    tick(1);
    chk("e_ctrl_e20", 32'(ctrl_out[3]), 32'h1);

    $display("[tb] estop and fault clear");
    start[1] = 1'b1;
    tick(1);
    chk("f_all_on", 32'(ctrl_out), 32'hF);
    estop = 1'b1;
    tick(1);
    estop = 1'b0;
    chk("f_ctrl_estop", 32'(ctrl_out), 32'h0);
    chk("f_fault_set", 32'(fault), 32'h1);
    chk("f_busy_estop", 32'(busy), 32'h0);
    tick(1);
    chk("f_fault_hold", 32'(fault), 32'h1);
    chk("f_ctrl_hold", 32'(ctrl_out), 32'h0);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("f_fault_clr", 32'(fault), 32'h0);
    tick(1);
    chk("f_restart_ctrl", 32'(ctrl_out), 32'h2);
    chk("f_restart_busy", 32'(busy), 32'hD);
    tick(2);
    chk("f_ch2_on", 32'(ctrl_out), 32'h6);

    $display("[tb] ch0 zero preset");
    cfg_write(2'd0, 28'd0);
    tick(1);
    chk("g_ch0_lowered", 32'(ctrl_out[0]), 32'h1);
    start[0] = 1'b0;
    tick(12);
    chk("g_ch0_off", 32'(ctrl_out[0]), 32'h0);
    start[0] = 1'b1;
    tick(1);
    chk("g_ch0_zero_on", 32'(ctrl_out[0]), 32'h1);
    chk("g_ch0_zero_busy", 32'(busy[0]), 32'h0);

    $display("[tb] reset during timing");
    start[3] = 1'b0;
    tick(12);
    start[3] = 1'b1;
    tick(3);
    chk("h_busy_pre", 32'(busy[3]), 32'h1);
    reset = 1'b1;
    #2;
    chk("h_ctrl_rst", 32'(ctrl_out), 32'h0);
    chk("h_busy_rst", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(1);
    chk("h_ctrl_fresh", 32'(ctrl_out), 32'h2);
    chk("h_busy_fresh", 32'(busy), 32'hD);
    tick(19);
    chk("h_ctrl_e19", 32'(ctrl_out), 32'h2);
    tick(1);
    chk("h_ctrl_e20", 32'(ctrl_out), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
